// File: rtl/vector_pkg.sv
// Shared widths, lane-index type and controller state encoding for the vector packer.
package vector_pkg;

  localparam int V      = 128;
  localparam int N      = 32;
  localparam int LANES  = V / N;
  localparam int LANE_W = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/vector_lane_insert.sv
// Combinational lane replacement: returns i_vec with lane i_lane overwritten by i_scalar.
module vector_lane_insert
  import vector_pkg::*;
#(
  parameter int V = vector_pkg::V,
  parameter int N = vector_pkg::N
) (
  input  logic [V-1:0] i_vec,
  input  logic [N-1:0] i_scalar,
  input  lane_idx_t    i_lane,
  output logic [V-1:0] o_vec
);

  always_comb begin
    o_vec = i_vec;
    o_vec[int'(i_lane)*N +: N] = i_scalar;
  end

endmodule

// File: rtl/vector_pack_ctrl.sv
// Packs up to four scalar beats into a vector seeded from base_vec and presents it
// on a valid/ready output; flush aborts the operation without emitting it.
module vector_pack_ctrl
  import vector_pkg::*;
#(
  parameter int V = vector_pkg::V,
  parameter int N = vector_pkg::N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [V-1:0] base_vec,
  input  logic         flush,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [V-1:0] m_data,
  output logic [2:0]   m_lanes,
  output logic         busy
);

  state_t         r_state;
  logic [V-1:0]   r_acc;
  lane_idx_t      r_lane_cnt;
  logic [2:0]     r_m_lanes;
  logic           r_s_ready;
  logic           r_m_valid;
  logic           r_busy;

  logic [V-1:0]   w_ins_vec;
  logic           w_beat;
  logic           w_final;

  vector_lane_insert #(
    .V (V),
    .N (N)
  ) u_insert (
    .i_vec    (r_acc),
    .i_scalar (s_data),
    .i_lane   (r_lane_cnt),
    .o_vec    (w_ins_vec)
  );

  assign w_beat  = s_valid & r_s_ready;
  assign w_final = (r_lane_cnt == lane_idx_t'(LANES - 1)) | s_last;

  // Outputs are registered alongside the state, so neither m_ready nor s_valid
  // reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_lane_cnt <= '0;
      r_m_lanes  <= '0;
      r_s_ready  <= 1'b0;
      r_m_valid  <= 1'b0;
      r_busy     <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_IDLE;
      r_lane_cnt <= '0;
      r_m_lanes  <= '0;
      r_s_ready  <= 1'b0;
      r_m_valid  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_FILL;
            r_acc      <= base_vec;
            r_lane_cnt <= '0;
            r_s_ready  <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_FILL: begin
          if (w_beat) begin
            r_acc <= w_ins_vec;
            if (w_final) begin
              r_state   <= ST_OUT;
              r_m_lanes <= {1'b0, r_lane_cnt} + 3'd1;
              r_s_ready <= 1'b0;
              r_m_valid <= 1'b1;
            end else begin
              r_lane_cnt <= r_lane_cnt + lane_idx_t'(1);
            end
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            r_state    <= ST_IDLE;
            r_lane_cnt <= '0;
            r_m_valid  <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_acc;
  assign m_lanes = r_m_lanes;
  assign busy    = r_busy;

endmodule

// File: tb/tb_vector_pack_ctrl.sv
// Scoreboard bench for vector_pack_ctrl: directed scenarios plus randomized packs
// checked against a lane-array reference model.
module tb_vector_pack_ctrl;

  localparam int V = 128;
  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [V-1:0] base_vec;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [V-1:0] m_data;
  logic [2:0]   m_lanes;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  logic [V-1:0] exp_q[$];
  logic [2:0]   lanes_q[$];

  vector_pack_ctrl #(.V(V), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_vec (base_vec),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_lanes  (m_lanes),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [V-1:0] act, input logic [V-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: base vector with the first n lanes replaced by the beats in order.
  function automatic logic [V-1:0] model(input logic [V-1:0] base,
                                         input logic [N-1:0] d0, d1, d2, d3,
                                         input int n);
    logic [N-1:0] beats [4];
    logic [V-1:0] r;
    beats[0] = d0; beats[1] = d1; beats[2] = d2; beats[3] = d3;
    r = base;
    for (int i = 0; i < n; i++) r[i*N +: N] = beats[i];
    return r;
  endfunction

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_ready = 1'($urandom_range(0, 1));
        1:       m_ready = 1'b1;
        default: m_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    logic [V-1:0] e;
    logic [2:0]   l;
    if (rst_n && m_valid && m_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h lanes=%0d required=no output", m_data, m_lanes);
      end else begin
        e = exp_q.pop_front();
        l = lanes_q.pop_front();
        chk("out_data", m_data, e);
        chk("out_lanes", {125'd0, m_lanes}, {125'd0, l});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 300) begin
      step();
      k++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic pack(input logic [V-1:0] base,
                      input logic [N-1:0] d0, d1, d2, d3,
                      input int n, input bit push, input bit ign, input int gap,
                      input bit use_exp, input logic [V-1:0] exp_in);
    logic [N-1:0] d [4];
    logic [V-1:0] e;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    e = use_exp ? exp_in : model(base, d0, d1, d2, d3, n);
    wait_idle();
    if (push) begin
      exp_q.push_back(e);
      lanes_q.push_back(3'(n));
    end
    start = 1'b1;
    base_vec = base;
    if (!rst_n) begin
      #2;
      rst_n = 1'b1;
    end
    step();
    start = 1'b0;
    base_vec = '0;
    chk("busy_fill", {127'd0, busy}, 128'd1);
    chk("s_ready_fill", {127'd0, s_ready}, 128'd1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap)) begin
        s_data = $urandom;
        s_last = 1'($urandom_range(0, 1));
        step();
      end
      s_valid = 1'b1;
      s_data  = d[i];
      s_last  = (i == n - 1) && (n < 4 || $urandom_range(0, 1) == 1);
      if (ign && i == 1) begin
        start = 1'b1;
        base_vec = ~base;
      end
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      start   = 1'b0;
      s_data  = $urandom;
    end
    @(negedge clk);
    chk("m_valid_latency", {127'd0, m_valid}, 128'd1);
    chk("s_ready_out", {127'd0, s_ready}, 128'd0);
  endtask

  initial begin : driver
    logic [V-1:0] e;
    logic [V-1:0] b;
    logic [N-1:0] r0, r1, r2, r3;
    int n;
    int k;
    rst_n = 1'b0; start = 1'b0; base_vec = '0; flush = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) step();
    chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("rst_s_ready", {127'd0, s_ready}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_m_data", m_data, 128'd0);
    chk("rst_m_lanes", {125'd0, m_lanes}, 128'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_ignores_start", {127'd0, busy}, 128'd0);

    // Full pack from zero base; also the first start after reset release.
    pack('0, 32'h11, 32'h22, 32'h33, 32'h44, 4, 1, 0, 0, 1,
         128'h00000044_00000033_00000022_00000011);
    // Early last.
    pack({V{1'b1}}, 32'hA, 32'hB, 32'h0, 32'h0, 2, 1, 0, 1, 1,
         128'hFFFFFFFF_FFFFFFFF_0000000B_0000000A);

    // Backpressure: output held stable for 5 cycles.
    rdy_mode = 2;
    b = {$urandom, $urandom, $urandom, $urandom};
    r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    e = model(b, r0, r1, r2, r3, 3);
    pack(b, r0, r1, r2, r3, 3, 1, 0, 0, 0, '0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_m_valid", {127'd0, m_valid}, 128'd1);
      chk("bp_m_data", m_data, e);
      chk("bp_m_lanes", {125'd0, m_lanes}, 128'd3);
      chk("bp_s_ready", {127'd0, s_ready}, 128'd0);
    end
    rdy_mode = 1;

    // Flush after two beats, asserted together with a beat and a start.
    wait_idle();
    start = 1'b1; base_vec = {4{32'h5A5A5A5A}};
    step();
    start = 1'b0;
    s_valid = 1'b1; s_data = 32'h1;
    step();
    s_data = 32'h2;
    step();
    flush = 1'b1; s_data = 32'h3; start = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0; start = 1'b0;
    chk("flush_busy", {127'd0, busy}, 128'd0);
    chk("flush_s_ready", {127'd0, s_ready}, 128'd0);
    chk("flush_m_lanes", {125'd0, m_lanes}, 128'd0);
    repeat (3) step();
    chk("flush_no_m_valid", {127'd0, m_valid}, 128'd0);
    b = {$urandom, $urandom, $urandom, $urandom};
    pack(b, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4, 1, 0, 0, 0, '0);

    // Flush in OUT beats a simultaneous m handshake.
    rdy_mode = 2;
    pack({4{32'h77777777}}, $urandom, $urandom, $urandom, $urandom, 4, 0, 0, 0, 0, '0);
    step();
    flush = 1'b1; rdy_mode = 1;
    step();
    flush = 1'b0;
    chk("flush_out_m_valid", {127'd0, m_valid}, 128'd0);
    chk("flush_out_busy", {127'd0, busy}, 128'd0);

    // Ignored start during FILL.
    b = {$urandom, $urandom, $urandom, $urandom};
    pack(b, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 4, 1, 1, 0, 0, '0);

    // Asynchronous reset between edges during FILL.
    wait_idle();
    start = 1'b1; base_vec = {4{32'hDEADBEEF}};
    step();
    start = 1'b0;
    s_valid = 1'b1; s_data = 32'hE0;
    step();
    s_data = 32'hE1;
    step();
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_data", m_data, 128'd0);
    chk("arst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("arst_s_ready", {127'd0, s_ready}, 128'd0);
    chk("arst_busy", {127'd0, busy}, 128'd0);
    chk("arst_m_lanes", {125'd0, m_lanes}, 128'd0);
    step();
    step();
    b = {$urandom, $urandom, $urandom, $urandom};
    pack(b, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 4, 1, 0, 0, 0, '0);

    // Randomized packs with random gaps, backpressure and stray starts.
    rdy_mode = 0;
    for (int t = 0; t < 40; t++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      n = $urandom_range(1, 4);
      pack(b, $urandom, $urandom, $urandom, $urandom, n, 1,
           (n >= 2) && ($urandom_range(0, 1) == 1), 2, 0, '0);
    end
    rdy_mode = 1;

    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
